// File: rtl/seq_mult_unit.sv
// Sequential 32x32 shift-add multiplier (MULT/MULTU) with a 64-bit hi/lo result.
// Fixed 33-cycle latency from start acceptance to the one-cycle done pulse.
module seq_mult_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [4:0]  r_count;
  logic        r_neg;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [63:0] w_prod;

  // Magnitudes for signed mode; 0x80000000 negates to itself and is used as unsigned.
  assign w_abs_a = (is_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_abs_b = (is_signed && B[31]) ? (~B + 32'd1) : B;
  assign w_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_mplier[0] ? r_mcand : 32'd0)};
  assign w_prod  = r_neg ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= is_signed & (A[31] ^ B[31]);
            r_acc    <= '0;
            r_count  <= '0;
            busy     <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          // Add into the upper half with carry, then shift the whole accumulator right.
          r_acc    <= {w_sum, r_acc[31:1]};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= FIX;
        end
        FIX: begin
          hi      <= w_prod[63:32];
          lo      <= w_prod[31:0];
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have these ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request to multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- A  input  32  multiplicand; sampled with start.
- B  input  32  multiplier; sampled with start.
- hi  output  32  upper product word; registered.
- lo  output  32  lower product word; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo valid and new.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-004 In IDLE with start=1 at edge k, SHALL latch operands and is_signed, set count=0, and go to CALC.
REQ-005 In IDLE with start=1, operand handling SHALL be:
- unsigned: latch A and B as-is.
- signed: latch |A| and |B| and record neg = A[31] XOR B[31].
- |0x80000000| SHALL be 0x80000000, treated as unsigned.
REQ-006 CALC SHALL run 32 shift-add iterations, one per edge (k+1..k+32):
- if the multiplier LSB is 1, add the 32-bit multiplicand into the upper half of the 64-bit accumulator, keeping the carry (33-bit add).
- then shift the accumulator and multiplier right by 1.
REQ-007 At edge k+32 (count=31) SHALL go to FIX.
REQ-008 In FIX, at edge k+33, SHALL:
- write hi/lo with the 64-bit product, two's-complement negated if neg=1 and is_signed=1.
- go to DONE.
REQ-009 done SHALL be 1 only while in DONE (edge k+33 to k+34); DONE SHALL return to IDLE unconditionally at the next edge.
REQ-010 busy SHALL be 1 exactly in CALC and FIX (edge k to k+33) and 0 in IDLE and DONE.
REQ-011 start while not in IDLE SHALL be ignored and SHALL NOT corrupt the operation in flight or queue a request.
REQ-012 Changes on A, B, or is_signed after edge k SHALL NOT affect the result.
REQ-013 hi/lo SHALL hold their last value until the next FIX write; they SHALL NOT show partial products.
REQ-014 Product arithmetic SHALL be exact over 64 bits, with no overflow flag.
REQ-015 Total latency SHALL be a fixed 33 cycles from start acceptance to done, independent of operand values, with no early termination on zero operands.
REQ-016 Back-to-back operation: start asserted in the IDLE cycle after DONE SHALL be accepted (minimum issue interval 35 cycles).

Reset
REQ-017 When rst_n=0 at a rising edge, SHALL force:
- state to IDLE; hi, lo, accumulator and count to 0.
- busy and done to 0.
REQ-018 Reset during CALC or FIX SHALL abort the operation with no done pulse; the first start after rst_n returns high SHALL be processed normally.
REQ-019 While rst_n=0, start SHALL be ignored.

Verification
REQ-020 Unsigned: A=7, B=6, is_signed=0 -> done at start+33; hi=0x00000000, lo=0x0000002A; busy high for 33 cycles.
REQ-021 Signed: A=0xFFFFFFFD (-3), B=5, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-022 Extremes:
- A=B=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
- A=B=0xFFFFFFFF signed -> hi=0, lo=1.
- A=B=0x80000000 signed -> hi=0x40000000, lo=0.
REQ-023 Start while busy: start at k with A=3, B=4, then start at k+5 with A=9, B=9 -> single done at k+33, lo=12, no second done.
REQ-024 Reset mid-op: start at k, rst_n=0 at k+10 for 1 cycle -> busy=0, hi=lo=0, no done; a new start of 2x2 then yields lo=4 after 33 cycles.
REQ-025 Zero operand: A=0, B=0x12345678 -> latency still 33; hi=lo=0, with the previous nonzero hi/lo held until the FIX edge.
